// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: reads two source registers through the register file's two ports,
// yielding port 2 to writeback, and forwards/snoops writeback so delivered operands are current.
module operand_fetch_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inValid,
    output logic                   inReady,
    input  logic [INDEX_WIDTH-1:0] inIndex1,
    input  logic [INDEX_WIDTH-1:0] inIndex2,
    input  logic [DATA_WIDTH-1:0]  inPayload,
    input  logic                   wbEnable,
    input  logic [INDEX_WIDTH-1:0] wbIndex,
    input  logic [DATA_WIDTH-1:0]  wbData,
    output logic [INDEX_WIDTH-1:0] rfIndex1,
    input  logic [DATA_WIDTH-1:0]  rfReadData1,
    output logic [INDEX_WIDTH-1:0] rfIndex2,
    input  logic [DATA_WIDTH-1:0]  rfReadData2,
    output logic [DATA_WIDTH-1:0]  rfWriteData2,
    output logic                   rfWriteEnable2,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [DATA_WIDTH-1:0]  outOperand1,
    output logic [DATA_WIDTH-1:0]  outOperand2,
    output logic [DATA_WIDTH-1:0]  outPayload,
    output logic [2:0]             debug_state
);

    typedef enum logic [2:0] {
        S_EMPTY      = 3'd0,
        S_LATCH_BOTH = 3'd1,
        S_LATCH_1    = 3'd2,
        S_PEND_2     = 3'd3,
        S_LATCH_2    = 3'd4,
        S_FULL       = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
    logic [DATA_WIDTH-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic [DATA_WIDTH-1:0]  payload_q, payload_d;
    logic                   fwd1_q, fwd1_d;
    logic [DATA_WIDTH-1:0]  fwd_data_q, fwd_data_d;

    logic                   idle_or_full;
    logic                   accept;
    logic [INDEX_WIDTH-1:0] read2_idx;
    logic [DATA_WIDTH-1:0]  cap1, cap2;
    logic                   snoop1, snoop2;

    always_comb begin
        idle_or_full   = (state_q == S_EMPTY) || (state_q == S_FULL);
        inReady        = (state_q == S_EMPTY) || ((state_q == S_FULL) && outReady);
        accept         = inValid && inReady;
        rfIndex1       = idle_or_full ? inIndex1 : idx1_q;
        read2_idx      = idle_or_full ? inIndex2 : idx2_q;
        rfIndex2       = wbEnable ? wbIndex : read2_idx;
        rfWriteData2   = wbData;
        rfWriteEnable2 = wbEnable && (wbIndex != '0) && !reset;
        outValid       = (state_q == S_FULL);
        outOperand1    = op1_q;
        outOperand2    = op2_q;
        outPayload     = payload_q;
        debug_state    = state_q;

        // Port 1 reads old data, so a write in the issue cycle is replayed from fwd_data_q.
        if (idx1_q == '0)                           cap1 = '0;
        else if (wbEnable && (wbIndex == idx1_q))   cap1 = wbData;
        else if (fwd1_q)                            cap1 = fwd_data_q;
        else                                        cap1 = rfReadData1;

        if (idx2_q == '0)                           cap2 = '0;
        else if (wbEnable && (wbIndex == idx2_q))   cap2 = wbData;
        else                                        cap2 = rfReadData2;

        snoop1 = wbEnable && (wbIndex == idx1_q) && (idx1_q != '0);
        snoop2 = wbEnable && (wbIndex == idx2_q) && (idx2_q != '0);
    end

    always_comb begin
        state_d    = state_q;
        idx1_d     = idx1_q;
        idx2_d     = idx2_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        payload_d  = payload_q;
        fwd1_d     = fwd1_q;
        fwd_data_d = fwd_data_q;

        case (state_q)
            S_LATCH_BOTH: begin
                op1_d   = cap1;
                op2_d   = cap2;
                state_d = S_FULL;
            end
            S_LATCH_1: begin
                op1_d   = cap1;
                state_d = wbEnable ? S_PEND_2 : S_LATCH_2;
            end
            S_PEND_2: begin
                if (snoop1) op1_d = wbData;
                if (!wbEnable) state_d = S_LATCH_2;
            end
            S_LATCH_2: begin
                if (snoop1) op1_d = wbData;
                op2_d   = cap2;
                state_d = S_FULL;
            end
            S_FULL: begin
                if (snoop1) op1_d = wbData;
                if (snoop2) op2_d = wbData;
                if (outReady) state_d = S_EMPTY;
            end
            default: ;
        endcase

        if (accept) begin
            idx1_d     = inIndex1;
            idx2_d     = inIndex2;
            payload_d  = inPayload;
            fwd1_d     = wbEnable && (wbIndex == inIndex1);
            fwd_data_d = wbData;
            state_d    = wbEnable ? S_LATCH_1 : S_LATCH_BOTH;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            idx1_q     <= '0;
            idx2_q     <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            payload_q  <= '0;
            fwd1_q     <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx1_q     <= idx1_d;
            idx2_q     <= idx2_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            payload_q  <= payload_d;
            fwd1_q     <= fwd1_d;
            fwd_data_q <= fwd_data_d;
        end
    end

endmodule
